// File: rtl/nios_led3_led_seq.sv
// LED sequencer: steps a 4-entry, 2-bit pattern table out to the LED PIO
// through an Avalon-MM write master. It is configured through a small CSR slave.
module nios_led3_led_seq #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  // CSR slave
  input  logic [1:0]          s_address,
  input  logic                s_chipselect,
  input  logic                s_write_n,
  input  logic [31:0]         s_writedata,
  output logic [31:0]         s_readdata,
  // LED PIO write master
  output logic [1:0]          m_address,
  output logic                m_chipselect,
  output logic                m_write_n,
  output logic [31:0]         m_writedata,
  input  logic                m_waitrequest,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, WRITE, COUNT} state_t;

  localparam int unsigned IDX_W = 2;

  state_t              state_q, state_d;
  logic                ctrl_en_q, ctrl_oneshot_q;
  logic [PERIOD_W-1:0] period_q;
  logic [7:0]          pattern_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PERIOD_W-1:0] counter_q, counter_d;
  logic                en_clr_c;
  logic                csr_wr_c;
  logic                m_chipselect_d, m_write_n_d, busy_d;
  logic [31:0]         m_writedata_d;
  logic                unused_wd;

  assign csr_wr_c  = s_chipselect & ~s_write_n;
  assign m_address = 2'd0;
  assign unused_wd = ^s_writedata;

  // Select one 2-bit entry from the pattern table
  function automatic logic [1:0] pat_entry(input logic [7:0] pat, input logic [IDX_W-1:0] i);
    case (i)
      2'd0:    pat_entry = pat[1:0];
      2'd1:    pat_entry = pat[3:2];
      2'd2:    pat_entry = pat[5:4];
      default: pat_entry = pat[7:6];
    endcase
  endfunction

  // CSR registers; a one-shot completion clears EN even against a concurrent CSR write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en_q      <= 1'b0;
      ctrl_oneshot_q <= 1'b0;
      period_q       <= '0;
      pattern_q      <= '0;
    end else begin
      if (csr_wr_c) begin
        case (s_address)
          2'd0: begin
            ctrl_en_q      <= s_writedata[0];
            ctrl_oneshot_q <= s_writedata[1];
          end
          2'd1:    period_q  <= s_writedata[PERIOD_W-1:0];
          2'd2:    pattern_q <= s_writedata[7:0];
          default: ;
        endcase
      end
      if (en_clr_c) ctrl_en_q <= 1'b0;
    end
  end

  // CSR read mux
  always_comb begin
    s_readdata = 32'd0;
    case (s_address)
      2'd0:    s_readdata = {30'd0, ctrl_oneshot_q, ctrl_en_q};
      2'd1:    s_readdata = 32'(period_q);
      2'd2:    s_readdata = {24'd0, pattern_q};
      default: s_readdata = {28'd0, idx_q, 1'b0, busy};
    endcase
  end

  // State, index, counter and registered master outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      counter_q    <= '0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= 32'd0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      counter_q    <= counter_d;
      m_chipselect <= m_chipselect_d;
      m_write_n    <= m_write_n_d;
      m_writedata  <= m_writedata_d;
      busy         <= busy_d;
    end
  end

  // Next-state logic; write payload is latched on WRITE entry and held while stalled
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    counter_d = counter_q;
    en_clr_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_en_q) begin
          state_d = WRITE;
          idx_d   = '0;
        end
      end
      WRITE: begin
        if (!m_waitrequest) begin
          if (!ctrl_en_q) begin
            state_d = IDLE;
          end else if (ctrl_oneshot_q && (idx_q == IDX_W'(3))) begin
            en_clr_c = 1'b1;
            state_d  = IDLE;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            counter_d = (period_q == '0) ? PERIOD_W'(1) : period_q;
            state_d   = COUNT;
          end
        end
      end
      COUNT: begin
        counter_d = counter_q - PERIOD_W'(1);
        if (!ctrl_en_q)                        state_d = IDLE;
        else if (counter_q <= PERIOD_W'(1))    state_d = WRITE;
      end
      default: state_d = IDLE;
    endcase

    m_chipselect_d = (state_d == WRITE);
    m_write_n_d    = (state_d != WRITE);
    busy_d         = (state_d != IDLE);
    m_writedata_d  = 32'd0;
    if (state_d == WRITE) begin
      if (state_q == WRITE) m_writedata_d = m_writedata;
      else                  m_writedata_d = {30'd0, pat_entry(pattern_q, idx_d)};
    end
  end

endmodule

// File: tb/tb_nios_led3_led_seq.sv
// Directed bench for the LED sequencer: CSR access, timing, one-shot, stalls, reset.
module tb_nios_led3_led_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  s_address;
  logic        s_chipselect;
  logic        s_write_n;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int          acc_cyc[$];
  logic [31:0] acc_data[$];
  logic [3:0]  acc_stat[$];

  nios_led3_led_seq #(.PERIOD_W(24)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record every accepted master write with its cycle number and STATUS view
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && m_chipselect && !m_write_n && !m_waitrequest) begin
      acc_cyc.push_back(cyc);
      acc_data.push_back(m_writedata);
      acc_stat.push_back(s_readdata[3:0]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
    @(negedge clk);
    s_chipselect = 1'b0; s_write_n = 1'b1; s_address = 2'd3;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    s_address = a;
    #1;
    d = s_readdata;
    s_address = 2'd3;
  endtask

  task automatic wait_accepts(input int n, input int budget);
    int k = 0;
    while (acc_cyc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("accept_count", 32'(acc_cyc.size()), 32'(n));
  endtask

  task automatic wait_cs(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_chipselect && k < budget);
    check("write_seen", 32'(m_chipselect), 32'd1);
  endtask

  task automatic clear_log();
    acc_cyc.delete(); acc_data.delete(); acc_stat.delete();
  endtask

  logic [31:0] rd;
  logic [31:0] held;

  initial begin
    reset_n = 1'b0; s_address = 2'd0; s_chipselect = 1'b0; s_write_n = 1'b1;
    s_writedata = 32'd0; m_waitrequest = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      csr_read(2'(a), rd);
      check($sformatf("reset_rd%0d", a), rd, 32'd0);
    end
    check("reset_write_n", 32'(m_write_n), 32'd1);
    check("reset_cs", 32'(m_chipselect), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Free-running sequence, unused bits ignored, STATUS not writable
    csr_write(2'd3, 32'hF);
    csr_read(2'd3, rd);
    check("status_ro", rd, 32'd0);
    csr_write(2'd1, 32'd4);
    csr_write(2'd2, 32'hFFFF_FFE4);
    csr_read(2'd2, rd);
    check("pattern_rd", rd, 32'h0000_00E4);
    clear_log();
    csr_write(2'd0, 32'd1);
    wait_accepts(5, 100);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("run_data%0d", i), acc_data[i], 32'(i % 4));
      check($sformatf("run_status%0d", i), 32'(acc_stat[i]), 32'({2'(i % 4), 2'b01}));
      if (i > 0) check($sformatf("run_gap%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd5);
    end
    csr_write(2'd0, 32'd0);
    repeat (2) @(negedge clk);
    check("run_stop_busy", 32'(busy), 32'd0);

    // One-shot: four writes then stop with EN cleared
    csr_write(2'd1, 32'd2);
    csr_write(2'd2, 32'h1B);
    clear_log();
    csr_write(2'd0, 32'd3);
    wait_accepts(4, 100);
    repeat (20) @(negedge clk);
    check("os_count", 32'(acc_cyc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("os_data%0d", i), acc_data[i], 32'(3 - i));
      if (i > 0) check($sformatf("os_gap%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
    end
    check("os_busy", 32'(busy), 32'd0);
    csr_read(2'd0, rd);
    check("os_ctrl", rd, 32'h2);
    csr_read(2'd3, rd);
    check("os_status", rd, 32'hC);

    // Stalled write: outputs hold, single accept, next write PERIOD+1 later
    csr_write(2'd1, 32'd4);
    csr_write(2'd2, 32'hE4);
    m_waitrequest = 1'b1;
    clear_log();
    csr_write(2'd0, 32'd1);
    wait_cs(20);
    held = m_writedata;
    check("stall_data0", held, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall_cs%0d", i), 32'(m_chipselect), 32'd1);
      check($sformatf("stall_wn%0d", i), 32'(m_write_n), 32'd0);
      check($sformatf("stall_hold%0d", i), m_writedata, held);
    end
    check("stall_no_accept", 32'(acc_cyc.size()), 32'd0);
    m_waitrequest = 1'b0;
    wait_accepts(1, 10);
    @(negedge clk);
    check("stall_single", 32'(acc_cyc.size()), 32'd1);
    wait_accepts(2, 50);
    check("stall_data1", acc_data[1], 32'd1);
    check("stall_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd5);

    // EN cleared during COUNT: idle next edge, no further write
    csr_write(2'd0, 32'd0);
    @(negedge clk);
    check("cnt_stop_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check("cnt_stop_count", 32'(acc_cyc.size()), 32'd2);

    // EN cleared during stalled WRITE: transfer completes, then idle
    m_waitrequest = 1'b1;
    clear_log();
    csr_write(2'd0, 32'd1);
    wait_cs(20);
    csr_write(2'd0, 32'd0);
    check("wr_stop_cs", 32'(m_chipselect), 32'd1);
    m_waitrequest = 1'b0;
    wait_accepts(1, 10);
    check("wr_stop_data", acc_data[0], 32'd0);
    check("wr_stop_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check("wr_stop_count", 32'(acc_cyc.size()), 32'd1);

    // PERIOD=0 behaves as 1
    csr_write(2'd1, 32'd0);
    clear_log();
    csr_write(2'd0, 32'd1);
    wait_accepts(3, 50);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("p0_data%0d", i), acc_data[i], 32'(i));
      if (i > 0) check($sformatf("p0_gap%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
    end

    // Reset mid-WRITE aborts the transfer and nothing restarts
    m_waitrequest = 1'b1;
    wait_cs(20);
    reset_n = 1'b0;
    #1;
    check("rst_cs", 32'(m_chipselect), 32'd0);
    check("rst_wn", 32'(m_write_n), 32'd1);
    check("rst_wd", m_writedata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    m_waitrequest = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_no_write", 32'(acc_cyc.size()), 32'd0);
    check("rst_idle", 32'(busy), 32'd0);
    csr_read(2'd0, rd);
    check("rst_ctrl", rd, 32'd0);
    csr_read(2'd1, rd);
    check("rst_period", rd, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
